// File: rtl/audio_note_seq_if.sv
// CPU-side note command bus and playback status for the audio note sequencer.
// The master drives note commands and abort; the slave (sequencer) returns status and tone.
interface audio_note_seq_if #(
    parameter int HALF_W = 24,
    parameter int DUR_W  = 16,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              note_valid;
    logic              note_ready;
    logic [HALF_W-1:0] note_half;
    logic [DUR_W-1:0]  note_dur;
    logic              abort;
    logic              tone_out;
    logic              busy;
    logic              note_done;
    logic [LVL_W-1:0]  fifo_level;

    modport master (
        output note_valid, note_half, note_dur, abort,
        input  note_ready, tone_out, busy, note_done, fifo_level
    );

    modport slave (
        input  note_valid, note_half, note_dur, abort,
        output note_ready, tone_out, busy, note_done, fifo_level
    );
endinterface

// File: rtl/audio_note_seq.sv
// Note sequencer: queues (half-period, duration) commands and plays each as a
// square wave for duration*TICK_DIV cycles, with an optional silent gap between notes.
module audio_note_seq #(
    parameter int HALF_W    = 24,
    parameter int DUR_W     = 16,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 0,
    parameter int DEPTH     = 4
) (
    input  logic            clkin,
    input  logic            rst,
    audio_note_seq_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_e;

    // Note storage: plain arrays, no reset, written only on an accepted push.
    logic [HALF_W-1:0] mem_half [DEPTH];
    logic [DUR_W-1:0]  mem_dur  [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              full, push, pop;
    logic [HALF_W-1:0] head_half;
    logic [DUR_W-1:0]  head_dur;

    state_e            state_q;
    logic [HALF_W-1:0] half_q;
    logic [HALF_W-1:0] tcnt_q;
    logic [DUR_W-1:0]  rem_q;
    logic [PSC_W-1:0]  psc_q;
    logic              tone_q;
    logic              note_done_q;
    logic              tick;
    logic              fifo_nonempty;
    logic              more_after_pop;

    assign full           = (count_q == LVL_W'(DEPTH));
    assign bus.note_ready = !full && !bus.abort;
    assign push           = bus.note_valid && bus.note_ready;
    assign pop            = (state_q == LOAD) && !bus.abort;
    assign head_half      = mem_half[rd_ptr_q];
    assign head_dur       = mem_dur[rd_ptr_q];
    assign fifo_nonempty  = (count_q != '0);
    assign more_after_pop = (count_q > LVL_W'(1));
    assign tick           = (psc_q == PSC_W'(TICK_DIV - 1));

    assign bus.tone_out   = tone_q;
    assign bus.note_done  = note_done_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.fifo_level = count_q;

    always_ff @(posedge clkin) begin
        if (push) begin
            mem_half[wr_ptr_q] <= bus.note_half;
            mem_dur[wr_ptr_q]  <= bus.note_dur;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            half_q      <= '0;
            tcnt_q      <= '0;
            rem_q       <= '0;
            psc_q       <= '0;
            tone_q      <= 1'b0;
            note_done_q <= 1'b0;
        end else begin
            note_done_q <= 1'b0;
            if (bus.abort) begin
                state_q <= IDLE;
                half_q  <= '0;
                tcnt_q  <= '0;
                rem_q   <= '0;
                psc_q   <= '0;
                tone_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fifo_nonempty) state_q <= LOAD;
                    end

                    LOAD: begin
                        half_q <= head_half;
                        tcnt_q <= '0;
                        psc_q  <= '0;
                        tone_q <= 1'b0;
                        if (head_dur == '0) begin
                            // Skipped note still reports completion.
                            note_done_q <= 1'b1;
                            rem_q       <= '0;
                            state_q     <= more_after_pop ? LOAD : IDLE;
                        end else begin
                            rem_q   <= head_dur;
                            state_q <= PLAY;
                        end
                    end

                    PLAY: begin
                        psc_q <= tick ? '0 : psc_q + 1'b1;
                        if (half_q != '0) begin
                            if (tcnt_q == half_q - 1'b1) begin
                                tcnt_q <= '0;
                                tone_q <= ~tone_q;
                            end else begin
                                tcnt_q <= tcnt_q + 1'b1;
                            end
                        end
                        if (tick) begin
                            if (rem_q == DUR_W'(1)) begin
                                // Final tick: silence overrides any toggle decided this cycle.
                                note_done_q <= 1'b1;
                                tone_q      <= 1'b0;
                                tcnt_q      <= '0;
                                if (GAP_TICKS > 0) begin
                                    rem_q   <= DUR_W'(GAP_TICKS);
                                    state_q <= GAP;
                                end else begin
                                    rem_q   <= '0;
                                    state_q <= fifo_nonempty ? LOAD : IDLE;
                                end
                            end else begin
                                rem_q <= rem_q - 1'b1;
                            end
                        end
                    end

                    GAP: begin
                        tone_q <= 1'b0;
                        psc_q  <= tick ? '0 : psc_q + 1'b1;
                        if (tick) begin
                            if (rem_q == DUR_W'(1)) begin
                                rem_q   <= '0;
                                state_q <= fifo_nonempty ? LOAD : IDLE;
                            end else begin
                                rem_q <= rem_q - 1'b1;
                            end
                        end
                    end

                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_audio_note_seq.sv
// Directed bench for audio_note_seq: single-note vector table plus multi-cycle
// sequences for FIFO fill, rest/skip, gap timing, abort and asynchronous reset.
module tb_audio_note_seq;
    localparam int HALF_W   = 24;
    localparam int DUR_W    = 16;
    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    audio_note_seq_if #(.HALF_W(HALF_W), .DUR_W(DUR_W), .DEPTH(DEPTH)) bus0();
    audio_note_seq_if #(.HALF_W(HALF_W), .DUR_W(DUR_W), .DEPTH(DEPTH)) bus1();

    audio_note_seq #(.HALF_W(HALF_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV),
                     .GAP_TICKS(0), .DEPTH(DEPTH))
        dut0 (.clkin(clk), .rst(rst), .bus(bus0));

    audio_note_seq #(.HALF_W(HALF_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV),
                     .GAP_TICKS(2), .DEPTH(DEPTH))
        dut1 (.clkin(clk), .rst(rst), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event logs, as cycle offsets from the push cycle of the current test.
    int t0 = 0, t1 = 0;
    int done0_q[$], hi0_q[$], done1_q[$], hi1_q[$];
    int busy_first0 = -1, busy_last1 = -1;

    always @(negedge clk) begin
        if (bus0.note_done) done0_q.push_back(cyc - t0);
        if (bus0.tone_out)  hi0_q.push_back(cyc - t0);
        if (bus0.busy && busy_first0 < 0) busy_first0 = cyc - t0;
        if (bus1.note_done) done1_q.push_back(cyc - t1);
        if (bus1.tone_out)  hi1_q.push_back(cyc - t1);
        if (bus1.busy) busy_last1 = cyc - t1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start0();
        t0 = cyc;
        done0_q.delete();
        hi0_q.delete();
        busy_first0 = -1;
    endtask

    task automatic start1();
        t1 = cyc;
        done1_q.delete();
        hi1_q.delete();
        busy_last1 = -1;
    endtask

    task automatic push0(input int h, input int d);
        bus0.note_valid = 1'b1;
        bus0.note_half  = HALF_W'(h);
        bus0.note_dur   = DUR_W'(d);
        step();
        bus0.note_valid = 1'b0;
    endtask

    task automatic push1(input int h, input int d);
        bus1.note_valid = 1'b1;
        bus1.note_half  = HALF_W'(h);
        bus1.note_dur   = DUR_W'(d);
        step();
        bus1.note_valid = 1'b0;
    endtask

    typedef struct {
        int half;
        int dur;
        int exp_done;
        int exp_high;
        int exp_first;
    } vec_t;

    vec_t vecs[6];
    int   fill_durs[6];
    int   fill_done[5];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int accepted;
        logic rdy;

        // Push at offset 0 -> IDLE at 1, LOAD at 2, PLAY from 3; done at 3+dur*4.
        vecs[0] = '{half: 3, dur: 2, exp_done: 11, exp_high: 3, exp_first: 6};
        vecs[1] = '{half: 1, dur: 1, exp_done: 7,  exp_high: 2, exp_first: 4};
        vecs[2] = '{half: 2, dur: 2, exp_done: 11, exp_high: 4, exp_first: 5};
        vecs[3] = '{half: 0, dur: 3, exp_done: 15, exp_high: 0, exp_first: -1};
        vecs[4] = '{half: 5, dur: 0, exp_done: 3,  exp_high: 0, exp_first: -1};
        vecs[5] = '{half: 4, dur: 1, exp_done: 7,  exp_high: 0, exp_first: -1};

        fill_durs = '{1, 2, 1, 3, 2, 1};
        fill_done = '{7, 16, 21, 34, 43};

        bus0.note_valid = 1'b0; bus0.note_half = '0; bus0.note_dur = '0; bus0.abort = 1'b0;
        bus1.note_valid = 1'b0; bus1.note_half = '0; bus1.note_dur = '0; bus1.abort = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tone",  int'(bus0.tone_out), 0);
        check("rst_busy",  int'(bus0.busy), 0);
        check("rst_done",  int'(bus0.note_done), 0);
        check("rst_level", int'(bus0.fifo_level), 0);
        check("rst_ready", int'(bus0.note_ready), 1);
        rst = 1'b1;
        step();

        // Single-note vector table
        for (int k = 0; k < 6; k++) begin
            start0();
            push0(vecs[k].half, vecs[k].dur);
            repeat (25) step();
            check($sformatf("v%0d_ndone", k), done0_q.size(), 1);
            check($sformatf("v%0d_done_at", k), (done0_q.size() > 0) ? done0_q[0] : -1, vecs[k].exp_done);
            check($sformatf("v%0d_high_cnt", k), hi0_q.size(), vecs[k].exp_high);
            check($sformatf("v%0d_first_high", k), (hi0_q.size() > 0) ? hi0_q[0] : -1, vecs[k].exp_first);
            check($sformatf("v%0d_busy_rise", k), busy_first0, 2);
            check($sformatf("v%0d_end_busy", k), int'(bus0.busy), 0);
            check($sformatf("v%0d_end_tone", k), int'(bus0.tone_out), 0);
        end

        // FIFO fill: valid held high; the sixth note must be refused while full
        start0();
        accepted = 0;
        for (int c = 0; c < 7; c++) begin
            bus0.note_valid = 1'b1;
            bus0.note_half  = HALF_W'(2);
            bus0.note_dur   = DUR_W'(fill_durs[accepted]);
            @(negedge clk);
            if (c == 5) begin
                check("fill_level", int'(bus0.fifo_level), 4);
                check("fill_ready", int'(bus0.note_ready), 0);
            end
            rdy = bus0.note_ready;
            step();
            if (rdy) accepted++;
        end
        bus0.note_valid = 1'b0;
        check("fill_accepted", accepted, 5);
        repeat (50) step();
        check("fill_ndone", done0_q.size(), 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("fill_done%0d", k), (done0_q.size() > k) ? done0_q[k] : -1, fill_done[k]);
        check("fill_end_busy", int'(bus0.busy), 0);

        // Rest then skipped note
        start0();
        push0(0, 3);
        push0(2, 0);
        repeat (25) step();
        check("rs_ndone", done0_q.size(), 2);
        check("rs_done_rest", (done0_q.size() > 0) ? done0_q[0] : -1, 15);
        check("rs_done_skip", (done0_q.size() > 1) ? done0_q[1] : -1, 16);
        check("rs_high_cnt", hi0_q.size(), 0);

        // Gap of 2 ticks between notes on the second instance
        start1();
        push1(1, 1);
        push1(1, 1);
        repeat (35) step();
        check("gap_ndone", done1_q.size(), 2);
        check("gap_done_a", (done1_q.size() > 0) ? done1_q[0] : -1, 7);
        check("gap_done_b", (done1_q.size() > 1) ? done1_q[1] : -1, 20);
        check("gap_high_cnt", hi1_q.size(), 4);
        check("gap_last_hi_a", (hi1_q.size() > 1) ? hi1_q[1] : -1, 6);
        check("gap_first_hi_b", (hi1_q.size() > 2) ? hi1_q[2] : -1, 17);
        check("gap_busy_last", busy_last1, 27);

        // Abort in PLAY cycle 5 with two queued notes and a simultaneous push
        start0();
        push0(3, 4);
        push0(2, 2);
        push0(2, 2);
        repeat (5) step();
        bus0.abort      = 1'b1;
        bus0.note_valid = 1'b1;
        bus0.note_half  = HALF_W'(1);
        bus0.note_dur   = DUR_W'(1);
        @(negedge clk);
        check("ab_pre_level", int'(bus0.fifo_level), 2);
        check("ab_pre_tone",  int'(bus0.tone_out), 1);
        check("ab_pre_ready", int'(bus0.note_ready), 0);
        step();
        bus0.abort      = 1'b0;
        bus0.note_valid = 1'b0;
        @(negedge clk);
        check("ab_level", int'(bus0.fifo_level), 0);
        check("ab_busy",  int'(bus0.busy), 0);
        check("ab_tone",  int'(bus0.tone_out), 0);
        check("ab_done",  int'(bus0.note_done), 0);
        repeat (30) step();
        check("ab_ndone",     done0_q.size(), 0);
        check("ab_end_busy",  int'(bus0.busy), 0);
        check("ab_end_level", int'(bus0.fifo_level), 0);

        // Asynchronous reset mid-PLAY
        start0();
        push0(3, 4);
        push0(2, 2);
        repeat (5) step();
        #1;
        check("ar_pre_level", int'(bus0.fifo_level), 1);
        check("ar_pre_tone",  int'(bus0.tone_out), 1);
        rst = 1'b0;
        #1;
        check("ar_tone",  int'(bus0.tone_out), 0);
        check("ar_busy",  int'(bus0.busy), 0);
        check("ar_level", int'(bus0.fifo_level), 0);
        check("ar_done",  int'(bus0.note_done), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) step();
        check("ar_post_busy",  int'(bus0.busy), 0);
        check("ar_post_level", int'(bus0.fifo_level), 0);
        check("ar_post_ndone", done0_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
